touch_pio_capture: RTL and testbench

TOUCH_PIO_CAPTURE -- requirements
Module: touch_pio_capture

---
 rtl/touch_pio_capture.sv | 164 ++++++++++++++++
 tb/tb_touch_pio_capture.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/touch_pio_capture.sv
`default_nettype none
// ============================================================================
// touch_pio_capture : synchronised, debounced input PIO with sticky change
// flag, 16-bit change counter and level IRQ behind an Avalon-MM slave.
// Revision 1.0 - initial release
// ============================================================================
module touch_pio_capture #(
    parameter int DATA_W      = 12,
    parameter int SYNC_STAGES = 2,
    parameter int STABLE_CNT  = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [1:0]        address,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic [31:0]       writedata,
    input  logic [DATA_W-1:0] in_port,
    output logic [31:0]       readdata,
    output logic              irq
);

    localparam int             CNT_W   = $clog2(STABLE_CNT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CNT);

    localparam logic [1:0] ADDR_DATA   = 2'd0;
    localparam logic [1:0] ADDR_IRQ_EN = 2'd1;
    localparam logic [1:0] ADDR_FLAG   = 2'd2;
    localparam logic [1:0] ADDR_COUNT  = 2'd3;

    generate
        if (DATA_W < 1 || DATA_W > 32) begin : g_bad_data_w
            $error("touch_pio_capture: DATA_W must be 1..32");
        end
        if (SYNC_STAGES < 2) begin : g_bad_sync_stages
            $error("touch_pio_capture: SYNC_STAGES must be >= 2");
        end
        if (STABLE_CNT < 1) begin : g_bad_stable_cnt
            $error("touch_pio_capture: STABLE_CNT must be >= 1");
        end
    endgenerate

    logic [SYNC_STAGES-1:0][DATA_W-1:0] sync_q;
    logic [DATA_W-1:0]                  synced;
    logic [DATA_W-1:0]                  cand;
    logic [CNT_W-1:0]                   cnt;
    logic [DATA_W-1:0]                  stable;
    logic                               change_evt;

    logic                               irq_en;
    logic                               change_flag;
    logic [15:0]                        change_count;

    logic                               wr_en;
    logic                               wr_irq_en;
    logic                               wr_flag_clr;
    logic                               wr_count_clr;
    logic [31:0]                        read_mux;
    logic                               unused_writedata;

    // ------------------------------------------------------------------
    // Input synchroniser: stage 0 captures the asynchronous pins.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], in_port};
        end
    end

    assign synced = sync_q[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // Debouncer: a candidate must be seen STABLE_CNT+1 times in a row.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cand <= '0;
            cnt  <= '0;
        end else if (synced != cand) begin
            cand <= synced;
            cnt  <= '0;
        end else if (cnt != CNT_MAX) begin
            cnt  <= cnt + CNT_W'(1);
        end
    end

    assign change_evt = (cnt == CNT_MAX) && (cand != stable);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stable <= '0;
        end else if (change_evt) begin
            stable <= cand;
        end
    end

    // ------------------------------------------------------------------
    // Register writes
    // ------------------------------------------------------------------
    assign wr_en        = chipselect && !write_n;
    assign wr_irq_en    = wr_en && (address == ADDR_IRQ_EN);
    assign wr_flag_clr  = wr_en && (address == ADDR_FLAG) && writedata[0];
    assign wr_count_clr = wr_en && (address == ADDR_COUNT);

    assign unused_writedata = ^writedata[31:1];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq_en <= 1'b0;
        end else if (wr_irq_en) begin
            irq_en <= writedata[0];
        end
    end

    // A change event on the same edge as a clear leaves the flag set.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            change_flag <= 1'b0;
        end else if (change_evt) begin
            change_flag <= 1'b1;
        end else if (wr_flag_clr) begin
            change_flag <= 1'b0;
        end
    end

    // A clear coinciding with an event counts that event.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            change_count <= 16'd0;
        end else if (wr_count_clr) begin
            change_count <= change_evt ? 16'd1 : 16'd0;
        end else if (change_evt) begin
            change_count <= change_count + 16'd1;
        end
    end

    // ------------------------------------------------------------------
    // Read path: always registered from the addressed register.
    // ------------------------------------------------------------------
    always_comb begin
        read_mux = '0;
        case (address)
            ADDR_DATA:   read_mux[DATA_W-1:0] = stable;
            ADDR_IRQ_EN: read_mux[0]          = irq_en;
            ADDR_FLAG:   read_mux[0]          = change_flag;
            ADDR_COUNT:  read_mux[15:0]       = change_count;
            default:     read_mux             = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata <= 32'd0;
            irq      <= 1'b0;
        end else begin
            readdata <= read_mux;
            irq      <= change_flag && irq_en;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_touch_pio_capture.sv
`default_nettype none
// Bench for touch_pio_capture: run-length reference model, directed corner
// cases and randomized Avalon traffic against changing input values.
module tb_touch_pio_capture;

    localparam int DATA_W      = 12;
    localparam int SYNC_STAGES = 2;
    localparam int STABLE_CNT  = 4;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic [1:0]        address = 2'd0;
    logic              chipselect = 1'b0;
    logic              write_n = 1'b1;
    logic [31:0]       writedata = 32'd0;
    logic [DATA_W-1:0] in_port = '0;
    logic [31:0]       readdata;
    logic              irq;

    always #5 clk = ~clk;

    touch_pio_capture #(
        .DATA_W      (DATA_W),
        .SYNC_STAGES (SYNC_STAGES),
        .STABLE_CNT  (STABLE_CNT)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .in_port    (in_port),
        .readdata   (readdata),
        .irq        (irq)
    );

    // Reference model: a delay line for the synchroniser and a run-length
    // view of the synced value; a run of more than STABLE_CNT identical
    // samples that differs from the current stable value is a change.
    logic [DATA_W-1:0] m_pipe [SYNC_STAGES];
    logic [DATA_W-1:0] m_run_val = '0;
    int                m_run_len = 1;
    logic [DATA_W-1:0] m_stable  = '0;
    logic              m_en      = 1'b0;
    logic              m_flag    = 1'b0;
    logic [15:0]       m_count   = 16'd0;
    logic [31:0]       m_rd      = 32'd0;
    logic              m_irq     = 1'b0;
    logic [DATA_W-1:0] m_s;
    logic              m_ev;
    logic              m_wr;
    int                preload_seq  = 0;
    int                preload_seen = 0;

    initial begin
        for (int i = 0; i < SYNC_STAGES; i++) m_pipe[i] = '0;
    end

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) m_pipe[i] = '0;
            m_run_val = '0;
            m_run_len = 1;
            m_stable  = '0;
            m_en      = 1'b0;
            m_flag    = 1'b0;
            m_count   = 16'd0;
            m_rd      = 32'd0;
            m_irq     = 1'b0;
        end else begin
            if (preload_seen != preload_seq) begin
                m_count      = 16'hFFFF;
                preload_seen = preload_seq;
            end
            m_s  = m_pipe[SYNC_STAGES-1];
            m_ev = (m_run_len > STABLE_CNT) && (m_run_val != m_stable);
            m_wr = chipselect && !write_n;
            case (address)
                2'd0:    m_rd = 32'(m_stable);
                2'd1:    m_rd = {31'd0, m_en};
                2'd2:    m_rd = {31'd0, m_flag};
                default: m_rd = {16'd0, m_count};
            endcase
            m_irq = m_flag & m_en;
            if (m_ev) m_stable = m_run_val;
            if (m_wr && address == 2'd1) m_en = writedata[0];
            if (m_ev) m_flag = 1'b1;
            else if (m_wr && address == 2'd2 && writedata[0]) m_flag = 1'b0;
            if (m_wr && address == 2'd3) m_count = m_ev ? 16'd1 : 16'd0;
            else if (m_ev) m_count = m_count + 16'd1;
            if (m_s == m_run_val) begin
                if (m_run_len < 1000) m_run_len = m_run_len + 1;
            end else begin
                m_run_val = m_s;
                m_run_len = 1;
            end
            for (int i = SYNC_STAGES - 1; i > 0; i--) m_pipe[i] = m_pipe[i-1];
            m_pipe[0] = in_port;
        end
    end

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests = tests + 1;
        if (act !== exp) begin
            fails = fails + 1;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance to the next falling edge and compare outputs with the model.
    task automatic tick();
        @(negedge clk);
        check("model_readdata", readdata, m_rd);
        check("model_irq", 32'(irq), 32'(m_irq));
    endtask

    task automatic reg_write(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        tick();
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic reg_read(input logic [1:0] a, output logic [31:0] d);
        address = a;
        tick();
        d = readdata;
    endtask

    logic [31:0] rv;
    int          hold;

    initial begin
        // Reset with in_port = 0
        repeat (3) tick();
        check("reset_readdata", readdata, 32'd0);
        check("reset_irq", 32'(irq), 32'd0);
        reset_n = 1'b1;
        repeat (2) tick();

        // 0x5A3 reaches stable after 8 edges, visible one edge later
        address = 2'd0;
        in_port = 12'h5A3;
        repeat (8) tick();
        check("addr0_before_latency", readdata, 32'd0);
        tick();
        check("addr0_stable_5a3", readdata, 32'h0000_05A3);
        reg_read(2'd3, rv);
        check("first_event_count", rv, 32'd1);

        // Short glitch is filtered
        reg_write(2'd3, 32'd0);
        reg_write(2'd2, 32'd1);
        address = 2'd0;
        in_port = 12'hFFF;
        repeat (3) tick();
        in_port = 12'h5A3;
        repeat (12) tick();
        reg_read(2'd0, rv);
        check("glitch_stable", rv, 32'h0000_05A3);
        reg_read(2'd3, rv);
        check("glitch_count", rv, 32'd0);
        reg_read(2'd2, rv);
        check("glitch_flag", rv, 32'd0);

        // Interrupt assert and clear
        reg_write(2'd1, 32'd1);
        address = 2'd2;
        in_port = 12'h123;
        repeat (8) tick();
        check("irq_before_flag", 32'(irq), 32'd0);
        tick();
        check("flag_set", readdata, 32'd1);
        check("irq_set", 32'(irq), 32'd1);
        reg_write(2'd2, 32'd1);
        check("irq_one_cycle_after_clear", 32'(irq), 32'd1);
        tick();
        check("irq_cleared", 32'(irq), 32'd0);

        // Event coincides with a flag clear: set wins
        in_port = 12'h456;
        repeat (7) tick();
        reg_write(2'd2, 32'd1);
        address = 2'd2;
        tick();
        check("flag_set_wins", readdata, 32'd1);

        // Event coincides with a counter clear: count ends at 1
        in_port = 12'h789;
        repeat (7) tick();
        reg_write(2'd3, 32'hDEAD_BEEF);
        address = 2'd3;
        tick();
        check("count_clear_with_event", readdata, 32'd1);

        // Counter wrap from 0xFFFF
        force dut.change_count = 16'hFFFF;
        release dut.change_count;
        preload_seq = preload_seq + 1;
        tick();
        check("count_preload", readdata, 32'h0000_FFFF);
        in_port = 12'hABC;
        repeat (10) tick();
        check("count_wrap", readdata, 32'd0);

        // Reset in the middle of a debounce
        address = 2'd0;
        in_port = 12'h0AA;
        repeat (4) tick();
        #2 reset_n = 1'b0;
        #1;
        check("midreset_readdata", readdata, 32'd0);
        check("midreset_irq", 32'(irq), 32'd0);
        repeat (2) tick();
        reset_n = 1'b1;
        repeat (8) tick();
        check("aborted_not_stable", readdata, 32'd0);
        tick();
        check("redebounced_value", readdata, 32'h0000_00AA);
        reg_read(2'd3, rv);
        check("redebounced_one_event", rv, 32'd1);

        // Randomized traffic
        for (int seg = 0; seg < 400; seg++) begin
            if ($urandom_range(0, 3) != 0) in_port = DATA_W'($urandom);
            hold = int'($urandom_range(1, 9));
            for (int j = 0; j < hold; j++) begin
                address = 2'($urandom);
                if ($urandom_range(0, 5) == 0) begin
                    chipselect = 1'b1;
                    write_n    = 1'b0;
                    writedata  = $urandom;
                end else begin
                    chipselect = 1'($urandom);
                    write_n    = 1'b1;
                    writedata  = $urandom;
                end
                tick();
                chipselect = 1'b0;
                write_n    = 1'b1;
            end
        end
        repeat (12) tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
